// File: rtl/joypad_scanner.sv
// rtl/joypad_scanner.sv - NES pad scanner with core passthrough; JOYPAD_DEBOUNCE_EN enables two-scan agreement on buttons
module joypad_scanner #(
    parameter int HALF_PERIOD   = 64,
    parameter int STROBE_CYCLES = 128,
    parameter int SCAN_PERIOD   = 357954
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       passthru,
    input  logic       scan_req,
    input  logic       nes_strobe,
    input  logic       nes_clock,
    output logic       nes_data,
    input  logic       joy_data,
    output logic       joy_strobe,
    output logic       joy_clock,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int MAXP_A = (HALF_PERIOD > STROBE_CYCLES) ? HALF_PERIOD : STROBE_CYCLES;
    localparam int MAXP   = (SCAN_PERIOD > MAXP_A) ? SCAN_PERIOD : MAXP_A;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] SB_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] SP_LAST = CW'((SCAN_PERIOD > 0) ? (SCAN_PERIOD - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        SETTLE,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    buttons_q, buttons_d;
    logic          pending_q, pending_d;
    logic          strobe_q, strobe_d;
    logic          clk_q, clk_d;
    logic          valid_q, valid_d;
    logic          nes_data_q, nes_data_d;
`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0]    raw_q, raw_d;
`endif

    logic timer_hit;
    logic any_req;
    logic start;
    logic pt_active;

    // Free-running scan period timer; a wrap is an auto-scan request
    always_comb begin
        timer_d   = '0;
        timer_hit = 1'b0;
        if (SCAN_PERIOD > 0) begin
            if (timer_q == SP_LAST) begin
                timer_d   = '0;
                timer_hit = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Request arbitration: the core owns the pins only while idle, so requests wait in pending
    always_comb begin
        any_req   = scan_req | timer_hit;
        pt_active = (state_q == IDLE) && passthru;
        start     = (state_q == IDLE) && !passthru && (any_req || pending_q);
        pending_d = pending_q;
        if (start) begin
            pending_d = 1'b0;
        end else if (any_req) begin
            pending_d = 1'b1;
        end
    end

    // Scan sequencer: next state, phase counter, bit capture and result update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
        raw_d     = raw_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            STROBE: begin
                if (cnt_q == SB_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == HP_LAST) begin
                    shift_d[0] = ~joy_data;
                    bit_d      = 3'd1;
                    state_d    = CLK_HI;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_HI: begin
                if (cnt_q == HP_LAST) begin
                    state_d = CLK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_LO: begin
                if (cnt_q == HP_LAST) begin
                    shift_d[bit_q] = ~joy_data;
                    cnt_d          = '0;
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = CLK_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
`ifdef JOYPAD_DEBOUNCE_EN
                if (shift_q == raw_q) begin
                    buttons_d = shift_q;
                end
                raw_d = shift_q;
`else
                buttons_d = shift_q;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Pin registers follow the next state so they toggle exactly with the phase boundaries
    always_comb begin
        strobe_d   = (state_d == STROBE);
        clk_d      = (state_d == CLK_HI);
        nes_data_d = pt_active ? joy_data : 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            pending_q  <= 1'b0;
            strobe_q   <= 1'b0;
            clk_q      <= 1'b0;
            valid_q    <= 1'b0;
            nes_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            pending_q  <= pending_d;
            strobe_q   <= strobe_d;
            clk_q      <= clk_d;
            valid_q    <= valid_d;
            nes_data_q <= nes_data_d;
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    // Raw byte of the previous scan for the agreement check
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end
`endif

    assign joy_strobe = pt_active ? nes_strobe : strobe_q;
    assign joy_clock  = pt_active ? nes_clock  : clk_q;
    assign nes_data   = nes_data_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_joypad_scanner.sv
// tb/tb_joypad_scanner.sv - scoreboard bench for joypad_scanner
module tb_joypad_scanner;

    localparam int LAT = 1 + 4 + 2 + 14 * 2 + 1;

    logic       clock = 1'b0;
    logic       reset_n, passthru, scan_req, nes_strobe, nes_clock;
    logic       nes_data, joy_data, joy_strobe, joy_clock, valid, busy;
    logic [7:0] buttons;

    logic       reset_n2;
    logic       nes_data2, joy_strobe2, joy_clock2, valid2, busy2;
    logic [7:0] buttons2;

    logic       jd_force = 1'b0;
    logic       jd_val = 1'b1;
    logic [7:0] pad_pins = 8'hFF;
    logic [3:0] idx = 4'd0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] btn;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    logic [7:0] m_btn = 8'h00;
    logic [7:0] m_raw = 8'h00;

    int   st_cnt = 0, hi_cnt = 0, pulses = 0;
    logic busy_prev = 1'b0, clk_prev = 1'b0, busy2_prev = 1'b0;
    int   starts2[$];
    int   valid2_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    joypad_scanner #(.HALF_PERIOD(2), .STROBE_CYCLES(4), .SCAN_PERIOD(0)) dut (
        .clock(clock), .reset_n(reset_n), .passthru(passthru), .scan_req(scan_req),
        .nes_strobe(nes_strobe), .nes_clock(nes_clock), .nes_data(nes_data),
        .joy_data(joy_data), .joy_strobe(joy_strobe), .joy_clock(joy_clock),
        .buttons(buttons), .valid(valid), .busy(busy)
    );

    joypad_scanner #(.HALF_PERIOD(2), .STROBE_CYCLES(4), .SCAN_PERIOD(100)) dut2 (
        .clock(clock), .reset_n(reset_n2), .passthru(1'b0), .scan_req(1'b0),
        .nes_strobe(1'b0), .nes_clock(1'b0), .nes_data(nes_data2),
        .joy_data(1'b0), .joy_strobe(joy_strobe2), .joy_clock(joy_clock2),
        .buttons(buttons2), .valid(valid2), .busy(busy2)
    );

    // Pad model: 4021-style shift register, loads on strobe, shifts on rising clock
    always @(posedge joy_strobe or posedge joy_clock) begin
        if (joy_strobe) idx <= 4'd0;
        else if (idx < 4'd8) idx <= idx + 4'd1;
    end
    assign joy_data = jd_force ? jd_val : ((idx < 4'd8) ? pad_pins[idx[2:0]] : 1'b1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pressed = inverted pin levels; optional agreement of two scans
    task automatic expect_scan(input logic [7:0] pins, input int at_cyc);
        logic [7:0] pressed;
        pressed = ~pins;
`ifdef JOYPAD_DEBOUNCE_EN
        if (pressed == m_raw) m_btn = pressed;
        m_raw = pressed;
`else
        m_btn = pressed;
`endif
        exp_q.push_back('{m_btn, at_cyc});
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 400) begin
            @(posedge clock); #1;
            w++;
        end
        check("drain_in_time", (w < 400), 1);
    endtask

    task automatic scan(input logic [7:0] pins);
        @(posedge clock); #1;
        pad_pins = pins;
        scan_req = 1'b1;
        expect_scan(pins, cyc + LAT);
        @(posedge clock); #1;
        scan_req = 1'b0;
        wait_drain();
    endtask

    // Monitor for the main instance: pin activity per scan and scoreboard pop on valid
    always @(negedge clock) begin
        if (reset_n) begin
            if (busy && !busy_prev) begin
                st_cnt = 0; hi_cnt = 0; pulses = 0;
            end
            if (joy_strobe) st_cnt++;
            if (joy_clock) hi_cnt++;
            if (joy_clock && !clk_prev) pulses++;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid=1 expected no scan (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("buttons", buttons, e.btn);
                    check("valid_cycle", cyc, e.cyc);
                    check("strobe_high_cycles", st_cnt, 4);
                    check("clock_high_cycles", hi_cnt, 14);
                    check("clock_pulses", pulses, 7);
                    check("busy_at_valid", busy, 0);
                end
            end
        end
        busy_prev = busy;
        clk_prev  = joy_clock;
    end

    // Monitor for the auto-scan instance
    always @(negedge clock) begin
        if (busy2 && !busy2_prev) starts2.push_back(cyc);
        if (valid2) valid2_cnt++;
        busy2_prev = busy2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, r, w, vsnap;
        logic v, ns, nc;
        logic [7:0] p;

        reset_n = 0; reset_n2 = 0; passthru = 0; scan_req = 0;
        nes_strobe = 0; nes_clock = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_strobe", joy_strobe, 0);
        check("rst_clock", joy_clock, 0);
        check("rst_nes_data", nes_data, 1);
        check("rst_buttons", buttons, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_nes_data", nes_data, 1);

        scan(8'hA5);
        for (int i = 0; i < 6; i++) scan(8'($urandom));
        scan(~8'h01);
        scan(~8'h02);
        scan(~8'h02);

        // Two extra requests during a scan collapse into one follow-up scan
        @(posedge clock); #1;
        p = 8'($urandom);
        pad_pins = p;
        t = cyc;
        scan_req = 1'b1;
        expect_scan(p, t + LAT);
        expect_scan(p, t + 2 * LAT);
        @(posedge clock); #1; scan_req = 1'b0;
        repeat (9) @(posedge clock);
        #1; scan_req = 1'b1;
        @(posedge clock); #1; scan_req = 1'b0;
        repeat (9) @(posedge clock);
        #1; scan_req = 1'b1;
        @(posedge clock); #1; scan_req = 1'b0;
        wait_drain();

        // Passthrough: pins follow the core, data forwarded one cycle later
        @(posedge clock); #1;
        passthru = 1'b1;
        jd_force = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 1'($urandom); ns = 1'($urandom); nc = 1'($urandom);
            jd_val = v; nes_strobe = ns; nes_clock = nc;
            #1;
            check("pt_strobe", joy_strobe, ns);
            check("pt_clock", joy_clock, nc);
            @(posedge clock); #1;
            check("pt_nes_data", nes_data, v);
        end
        scan_req = 1'b1;
        @(posedge clock); #1; scan_req = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("pt_no_scan", busy, 0);
        nes_strobe = 0; nes_clock = 0; jd_force = 0;
        p = 8'($urandom);
        pad_pins = p;
        passthru = 1'b0;
        t = cyc;
        expect_scan(p, t + LAT);
        wait_drain();
        check("owned_nes_data", nes_data, 1);

        // Auto scan every 100 cycles on the second instance
        @(posedge clock); #1;
        reset_n2 = 1'b1;
        r = cyc;
        w = 0;
        while (starts2.size() < 4 && w < 600) begin
            @(posedge clock); #1;
            w++;
        end
        check("auto_scan_count", starts2.size(), 4);
        if (starts2.size() >= 4) begin
            check("auto_first_start", starts2[0], r + 100);
            for (int k = 0; k < 3; k++) check("auto_period", starts2[k+1] - starts2[k], 100);
            check("auto_valids", valid2_cnt, 3);
        end

        // Reset in the middle of a clock-high phase
        w = 0;
        while (!joy_clock2 && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        check("reached_clk_hi", joy_clock2, 1);
        reset_n2 = 1'b0;
        vsnap = valid2_cnt;
        @(posedge clock);
        @(negedge clock);
        check("midrst_strobe", joy_strobe2, 0);
        check("midrst_clock", joy_clock2, 0);
        check("midrst_busy", busy2, 0);
        check("midrst_buttons", buttons2, 0);
        check("midrst_nes_data", nes_data2, 1);
        repeat (2) @(posedge clock);
        #1; reset_n2 = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("midrst_no_valid", valid2_cnt, vsnap);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
